// File: rtl/fir_cap_pkg.sv
// Shared types and constants for the fir_filter result capture block.
// FIR_CAP_TSTAMP_EN (optional) enables the trigger timestamp in fir_result_capture.
package fir_cap_pkg;

  localparam int CAP_DATA_W = 10;
  localparam int TSTAMP_W   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/fir_cap_mem.sv
// Capture window storage: DEPTH x DATA_W registers, synchronous write and
// asynchronous read so readout data is available in the same cycle as the pointer.
module fir_cap_mem
  import fir_cap_pkg::*;
#(
  parameter int DATA_W = CAP_DATA_W,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // No reset on the array: contents are only meaningful after a completed capture.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/fir_result_capture.sv
// Arms on command, triggers when the filter result reaches a threshold, records DEPTH
// samples and plays them back over valid/ready. FIR_CAP_TSTAMP_EN adds o_trig_time.
module fir_result_capture
  import fir_cap_pkg::*;
#(
  parameter int DATA_W = CAP_DATA_W,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_arm,
  input  logic [DATA_W-1:0] i_thresh,
  input  logic              i_abort,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic              o_armed,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_count
`ifdef FIR_CAP_TSTAMP_EN
  ,
  output logic [TSTAMP_W-1:0] o_trig_time
`endif
);

  localparam int AW = CNT_W - 1;

  cap_state_e        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              armed_q, busy_q, done_q, rd_valid_q;
  logic              we;
  logic              trig;
  logic              rd_xfer;
  logic [DATA_W-1:0] mem_rdata;

  assign trig    = (state_q == ARMED) && !i_abort && (i_result >= i_thresh);
  assign rd_xfer = rd_valid_q && i_rd_ready;

  // Abort overrides everything; the last write leaves wr_ptr at DEPTH-1 so it never wraps.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    we       = 1'b0;
    if (i_abort) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_arm) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          if (trig) begin
            we       = 1'b1;
            state_d  = CAPTURE;
            wr_ptr_d = AW'(1);
            count_d  = CNT_W'(1);
          end
        end
        CAPTURE: begin
          we      = 1'b1;
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(DEPTH - 1)) begin
            state_d = DONE;
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
        DONE: begin
          if (rd_xfer) begin
            count_d  = count_q - CNT_W'(1);
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (count_q == CNT_W'(1)) begin
              state_d  = IDLE;
              wr_ptr_d = '0;
              rd_ptr_d = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Status flags are decoded from the next state so they line up with state_q.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      armed_q    <= (state_d == ARMED);
      busy_q     <= (state_d == ARMED) || (state_d == CAPTURE);
      done_q     <= (state_d == DONE);
      rd_valid_q <= (state_d == DONE);
    end
  end

  fir_cap_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (we),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_result),
    .i_raddr (rd_ptr_q),
    .o_rdata (mem_rdata)
  );

  assign o_rd_data  = rd_valid_q ? mem_rdata : '0;
  assign o_rd_valid = rd_valid_q;
  assign o_armed    = armed_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_count    = count_q;

`ifdef FIR_CAP_TSTAMP_EN
  logic [TSTAMP_W-1:0] cyc_q;
  logic [TSTAMP_W-1:0] trig_time_q;

  // Free-running cycle counter; its pre-increment value is latched on the trigger edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cyc_q       <= '0;
      trig_time_q <= '0;
    end else begin
      cyc_q <= cyc_q + TSTAMP_W'(1);
      if (trig) begin
        trig_time_q <= cyc_q;
      end
    end
  end

  assign o_trig_time = trig_time_q;
`endif

endmodule

// File: tb/tb_fir_result_capture.sv
// Self-checking bench for fir_result_capture: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the capture window.
module tb_fir_result_capture;

  localparam int DATA_W = 10;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b1;
  logic [DATA_W-1:0] i_result = '0;
  logic              i_arm = 1'b0;
  logic [DATA_W-1:0] i_thresh = '0;
  logic              i_abort = 1'b0;
  logic              i_rd_ready = 1'b0;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  logic              o_armed;
  logic              o_busy;
  logic              o_done;
  logic [CNT_W-1:0]  o_count;
`ifdef FIR_CAP_TSTAMP_EN
  logic [15:0]       o_trig_time;
`endif

  fir_result_capture #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_result   (i_result),
    .i_arm      (i_arm),
    .i_thresh   (i_thresh),
    .i_abort    (i_abort),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid),
    .i_rd_ready (i_rd_ready),
    .o_armed    (o_armed),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_count    (o_count)
`ifdef FIR_CAP_TSTAMP_EN
    ,
    .o_trig_time(o_trig_time)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Model: what the block is doing, and the samples it currently holds.
  typedef enum int {M_IDLE, M_WAIT, M_FILL, M_READ} mode_e;
  mode_e       mMode;
  int          mBuf[$];
  logic [15:0] edgeCount;
  logic [15:0] expTrig;

  int          assertCount = 0;
  int          failCount = 0;
  int          cycIdx = 0;
  int          xferCount = 0;
  int          readLog[$];

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mMode = M_IDLE;
    mBuf.delete();
    edgeCount = '0;
    expTrig = '0;
  endtask

  task automatic modelStep(input logic [DATA_W-1:0] res, input logic arm,
                           input logic [DATA_W-1:0] thr, input logic abort, input logic ready);
    if (abort) begin
      mMode = M_IDLE;
      mBuf.delete();
    end else begin
      case (mMode)
        M_IDLE: if (arm) mMode = M_WAIT;
        M_WAIT: begin
          if (res >= thr) begin
            expTrig = edgeCount;
            mBuf.push_back(int'(res));
            mMode = M_FILL;
          end
        end
        M_FILL: begin
          mBuf.push_back(int'(res));
          if (mBuf.size() == DEPTH) mMode = M_READ;
        end
        M_READ: begin
          if (ready) begin
            void'(mBuf.pop_front());
            if (mBuf.size() == 0) mMode = M_IDLE;
          end
        end
      endcase
    end
    edgeCount = edgeCount + 16'd1;
  endtask

  task automatic checkOutput();
    check1("armed", 32'(o_armed), 32'(mMode == M_WAIT));
    check1("busy", 32'(o_busy), 32'(mMode == M_WAIT || mMode == M_FILL));
    check1("done", 32'(o_done), 32'(mMode == M_READ));
    check1("rd_valid", 32'(o_rd_valid), 32'(mMode == M_READ));
    check1("count", 32'(o_count), 32'(mBuf.size()));
    check1("rd_data", 32'(o_rd_data), (mMode == M_READ) ? 32'(mBuf[0]) : 32'd0);
`ifdef FIR_CAP_TSTAMP_EN
    check1("trig_time", 32'(o_trig_time), 32'(expTrig));
`endif
  endtask

  // Called just after a falling edge: drive, clock once, then check at the next falling edge.
  task automatic applyStimulus(input logic [DATA_W-1:0] res, input logic arm,
                               input logic [DATA_W-1:0] thr, input logic abort, input logic ready);
    i_result = res;
    i_arm = arm;
    i_thresh = thr;
    i_abort = abort;
    i_rd_ready = ready;
    #1;
    if (o_rd_valid && ready && !abort) begin
      xferCount++;
      readLog.push_back(int'(o_rd_data));
    end
    @(posedge i_clk);
    modelStep(res, arm, thr, abort, ready);
    @(negedge i_clk);
    cycIdx++;
    checkOutput();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) applyStimulus('0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int basicSeq[16] = '{6, 4, 1, 5, 2, 5, 1, 0, 7, 2, 2, 0, 3, 3, 3, 3};
    int bpSeq[$];
    int start;
    int doneAt;
    int guard;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] thr;

    // Reset asserted off the clock edge must clear outputs immediately.
    modelReset();
    #1 i_rst_n = 1'b0;
    #2;
    checkOutput();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus('0, 1'b0, '0, 1'b0, 1'b1);

    // Basic capture with full-speed readout.
    for (int i = 0; i < 8; i++) applyStimulus('0, 1'b0, 10'd1, 1'b0, 1'b1);
    applyStimulus('0, 1'b1, 10'd1, 1'b0, 1'b1);
    start = cycIdx;
    doneAt = -1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(10'(basicSeq[i]), 1'b0, 10'd1, 1'b0, 1'b1);
      if (o_done && doneAt < 0) doneAt = cycIdx - start;
    end
    guard = 0;
    while (doneAt < 0 && guard < 20) begin
      applyStimulus('0, 1'b0, 10'd1, 1'b0, 1'b0);
      if (o_done) doneAt = cycIdx - start;
      guard++;
    end
    check1("done_latency", 32'(doneAt), 32'd16);
    readLog.delete();
    xferCount = 0;
    for (int i = 0; i < 18; i++) applyStimulus('0, (i == 15), 10'd1, 1'b0, 1'b1);
    check1("basic_xfers", 32'(xferCount), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < readLog.size()) check1("basic_read", 32'(readLog[i]), 32'(basicSeq[i]));
    check1("idle_after_last_arm", 32'(o_armed), 32'd0);

    // Backpressure; threshold 0 triggers on the first armed cycle; arm in DONE ignored.
    applyStimulus('0, 1'b1, '0, 1'b0, 1'b0);
    bpSeq.delete();
    for (int i = 0; i < 16; i++) begin
      r = 10'($urandom_range(0, 1023));
      bpSeq.push_back(int'(r));
      applyStimulus(r, (i == 5), '0, 1'b0, 1'b0);
      if (i == 0) check1("thresh0_trigger", 32'(o_count), 32'd1);
    end
    readLog.delete();
    xferCount = 0;
    guard = 0;
    while (xferCount < 16 && guard < 80) begin
      applyStimulus('0, (guard % 4 == 2), '0, 1'b0, (guard % 3 == 0));
      guard++;
    end
    check1("bp_xfers", 32'(xferCount), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < readLog.size()) check1("bp_read", 32'(readLog[i]), 32'(bpSeq[i]));
    drain(2);

    // Threshold equality.
    applyStimulus('0, 1'b1, 10'd5, 1'b0, 1'b1);
    applyStimulus(10'd4, 1'b0, 10'd5, 1'b0, 1'b1);
    applyStimulus(10'd4, 1'b0, 10'd5, 1'b0, 1'b1);
    check1("below_thresh_count", 32'(o_count), 32'd0);
    applyStimulus(10'd5, 1'b0, 10'd5, 1'b0, 1'b1);
    check1("equal_thresh_count", 32'(o_count), 32'd1);
    for (int i = 0; i < 15; i++) applyStimulus(10'($urandom_range(0, 1023)), 1'b0, 10'd5, 1'b0, 1'b1);
    drain(18);

    // Abort at count 7 with arm pulses during capture, then a full re-armed capture.
    applyStimulus('0, 1'b1, '0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(10'($urandom_range(0, 1023)), i[0], '0, 1'b0, 1'b1);
    check1("count_before_abort", 32'(o_count), 32'd7);
    applyStimulus(10'd9, 1'b1, '0, 1'b1, 1'b1);
    check1("count_after_abort", 32'(o_count), 32'd0);
    applyStimulus('0, 1'b1, 10'd100, 1'b0, 1'b1);
    applyStimulus(10'd150, 1'b0, 10'd100, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(10'($urandom_range(0, 1023)), 1'b0, 10'd100, 1'b0, 1'b1);
    check1("rearm_done", 32'(o_done), 32'd1);
    drain(18);

    // Asynchronous reset in the middle of a capture.
    applyStimulus('0, 1'b1, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(10'($urandom_range(0, 1023)), 1'b0, '0, 1'b0, 1'b1);
    #2 i_rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(10'($urandom_range(0, 1023)), 1'b0, '0, 1'b0, 1'b1);

    // Random traffic.
    thr = 10'($urandom_range(0, 1023));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) thr = 10'($urandom_range(0, 1023));
      applyStimulus(10'($urandom_range(0, 1023)), ($urandom_range(0, 7) == 0), thr,
                    ($urandom_range(0, 79) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
